// File: rtl/mem_responder.sv
// mem_responder: wait-state memory model answering the multi-cycle
// controller's read/write requests with a one-cycle ready pulse.
module mem_responder #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned DEPTH_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam int unsigned IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t        state, state_nx;
   logic [3:0]    cnt, cnt_nx;
   logic [31:0]   lat_addr, lat_wdata;
   logic          lat_rd, lat_wr;
   logic [31:0]   op_addr, op_wdata;
   logic          op_rd, op_wr;
   logic          op_err;
   logic          commit;
   logic          err_q;
   logic [IW-1:0] idx;
   logic [31:0]   mem [DEPTH_WORDS];

   // Operation seen at the commit edge: the live inputs when committing
   // straight from IDLE (zero wait states), otherwise the latched copy.
   always_comb begin
      op_addr  = lat_addr;
      op_wdata = lat_wdata;
      op_rd    = lat_rd;
      op_wr    = lat_wr;
      if (state == ST_IDLE) begin
         op_addr  = addr;
         op_wdata = wdata;
         op_rd    = req_read;
         op_wr    = req_write;
      end
      idx    = op_addr[IW+1:2];
      op_err = (op_rd && op_wr)
            || (op_addr[1:0] != 2'b00)
            || ({2'b00, op_addr[31:2]} >= DEPTH_WORDS);
   end

   // Next-state, wait counter and commit strobe.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      commit   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_read || req_write) begin
               if (WAIT_CYCLES == 0) begin
                  state_nx = ST_RESP;
                  commit   = 1'b1;
               end else begin
                  state_nx = ST_WAIT;
                  cnt_nx   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_nx = ST_RESP;
               commit   = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         ST_RESP: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Status outputs decoded from the state; err is qualified by ready.
   always_comb begin
      ready = (state == ST_RESP);
      busy  = (state != ST_IDLE);
      err   = (state == ST_RESP) && err_q;
   end

   // Control state, request latch and registered read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
         err_q     <= 1'b0;
         rdata     <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if ((state == ST_IDLE) && (req_read || req_write)) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_rd    <= req_read;
            lat_wr    <= req_write;
         end
         if (commit) begin
            err_q <= op_err;
            if (op_err) begin
               rdata <= '0;
            end else if (op_rd) begin
               rdata <= mem[idx];
            end
         end
      end
   end

   // Data array: no reset, written only by a committed error-free write.
   always_ff @(posedge clk) begin
      if (commit && !op_err && op_wr) begin
         mem[idx] <= op_wdata;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench; one responder with two wait
// states and one with none share the same request stimulus.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_read, req_write;
   logic [31:0] addr, wdata;
   logic [31:0] rdata2, rdata0;
   logic        ready2, ready0, err2, err0, busy2, busy0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] mem_m [2][64];
   logic [31:0] rd_m  [2];

   mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(64)) u_dut2 (
      .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
      .addr(addr), .wdata(wdata), .rdata(rdata2), .ready(ready2),
      .err(err2), .busy(busy2));

   mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(64)) u_dut0 (
      .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
      .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0),
      .err(err0), .busy(busy0));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] o_rdata(input int sel);
      return (sel != 0) ? rdata2 : rdata0;
   endfunction
   function automatic logic o_ready(input int sel);
      return (sel != 0) ? ready2 : ready0;
   endfunction
   function automatic logic o_err(input int sel);
      return (sel != 0) ? err2 : err0;
   endfunction
   function automatic logic o_busy(input int sel);
      return (sel != 0) ? busy2 : busy0;
   endfunction

   // One request on both instances; instance sel is checked (1: 2 waits, 0: none).
   task automatic do_txn(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
      logic        e_err;
      int          lat;
      int          n;
      exp_t        e;
      e_err = (rd && wr) || (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
      for (int m = 0; m < 2; m++) begin
         if (e_err)   rd_m[m] = '0;
         else if (wr) mem_m[m][a[7:2]] = d;
         else         rd_m[m] = mem_m[m][a[7:2]];
      end
      sbq.push_back('{rdata: rd_m[sel], err: e_err});
      lat = (sel != 0) ? 2 : 0;

      req_read = rd; req_write = wr; addr = a; wdata = d;
      @(posedge clk); #1;
      // Scramble the bus while the transaction is in flight.
      req_read = 1'b0; req_write = 1'b0; addr = ~a; wdata = ~d;
      chk("busy_at_req", 32'(o_busy(sel)), 32'd1);
      n = 0;
      while (!o_ready(sel) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, lat);
      e = sbq.pop_front();
      chk("ready", 32'(o_ready(sel)), 32'd1);
      chk("rdata", o_rdata(sel), e.rdata);
      chk("err", 32'(o_err(sel)), 32'(e.err));
      @(posedge clk); #1;
      chk("ready_drop", 32'(o_ready(sel)), 32'd0);
      chk("busy_drop", 32'(o_busy(sel)), 32'd0);
      chk("err_idle", 32'(o_err(sel)), 32'd0);
      chk("rdata_hold", o_rdata(sel), e.rdata);
   endtask

   initial begin
      int pulses;
      rst = 1'b1; req_read = 1'b0; req_write = 1'b0; addr = '0; wdata = '0;
      rd_m[0] = '0; rd_m[1] = '0;
      for (int i = 0; i < 64; i++) begin
         mem_m[0][i] = '0; mem_m[1][i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdata", rdata2, 32'h0);
      chk("rst_ready", 32'(ready2), 32'd0);
      chk("rst_busy", 32'(busy2), 32'd0);
      chk("rst_err", 32'(err2), 32'd0);
      chk("rst_rdata0", rdata0, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic write then read-back, rdata holding afterwards.
      do_txn(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      do_txn(1, 1'b1, 1'b0, 32'h10, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rdata_idle_hold", rdata2, 32'hDEADBEEF);

      // Error cases, then the array must be intact.
      do_txn(1, 1'b1, 1'b0, 32'h12,  32'h0);
      do_txn(1, 1'b1, 1'b0, 32'h100, 32'h0);
      do_txn(1, 1'b1, 1'b1, 32'h10,  32'h11111111);
      do_txn(1, 1'b0, 1'b1, 32'h12,  32'h22222222);
      do_txn(1, 1'b1, 1'b0, 32'h10,  32'h0);

      // Last legal word.
      do_txn(1, 1'b0, 1'b1, 32'hFC, 32'h0000_55AA);
      do_txn(1, 1'b1, 1'b0, 32'hFC, 32'h0);

      // Reset during the wait states of a write.
      do_txn(1, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5);
      do_txn(1, 1'b1, 1'b0, 32'h8, 32'h0);
      req_write = 1'b1; addr = 32'h8; wdata = 32'h12345678;
      @(posedge clk); #1;
      req_write = 1'b0; addr = 32'h0; wdata = 32'h0;
      chk("busy_before_rst", 32'(busy2), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ready", 32'(ready2), 32'd0);
      chk("async_rst_busy", 32'(busy2), 32'd0);
      chk("async_rst_err", 32'(err2), 32'd0);
      chk("async_rst_rdata", rdata2, 32'h0);
      #2 rst = 1'b0;
      rd_m[0] = '0; rd_m[1] = '0;
      mem_m[0][2] = 32'h12345678;
      @(posedge clk); #1;
      do_txn(1, 1'b1, 1'b0, 32'h8, 32'h0);

      // Zero wait states with the write request held for four edges.
      pulses = 0;
      req_write = 1'b1; addr = 32'h4; wdata = 32'h0BADF00D;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("b2b_ready", 32'(ready0), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("b2b_busy", 32'(busy0), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("b2b_err", 32'(err0), 32'd0);
         pulses += int'(ready0);
      end
      req_write = 1'b0;
      @(posedge clk); #1;
      chk("b2b_final_ready", 32'(ready0), 32'd0);
      chk("b2b_pulses", pulses, 2);
      mem_m[0][1] = 32'h0BADF00D; mem_m[1][1] = 32'h0BADF00D;
      repeat (2) @(posedge clk);
      #1;
      do_txn(0, 1'b1, 1'b0, 32'h4, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
